// File: rtl/byte_mem_responder_pkg.sv
// Shared definitions for the byte-addressable memory responder:
// store-size encodings, FSM state type and a byte-count helper.
package mem_pkg;

    localparam logic [1:0] WR_NONE = 2'b00;
    localparam logic [1:0] WR_BYTE = 2'b01;
    localparam logic [1:0] WR_HALF = 2'b10;
    localparam logic [1:0] WR_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        WRITE = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Number of bytes a store of the given size commits (0 for no store).
    function automatic logic [2:0] byteCount(input logic [1:0] size);
        logic [2:0] count;
        count = 3'd0;
        case (size)
            WR_BYTE: count = 3'd1;
            WR_HALF: count = 3'd2;
            WR_WORD: count = 3'd4;
            default: count = 3'd0;
        endcase
        return count;
    endfunction

endpackage

// File: rtl/byte_mem_responder_byte_bank.sv
// One byte-wide memory bank: DEPTH_BYTES/4 rows of 8 bits, holding every
// byte whose index satisfies index[1:0] == LANE. Synchronous write port,
// registered read port with a read enable so the read data can be held.
module byte_bank #(
   parameter int    DEPTH_BYTES = 4096,
   parameter int    LANE        = 0,
   parameter string INIT_FILE   = ""
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             we_i,
   input  logic [$clog2(DEPTH_BYTES/4)-1:0] wrRow_i,
   input  logic [7:0]                       wrData_i,
   input  logic                             re_i,
   input  logic [$clog2(DEPTH_BYTES/4)-1:0] rdRow_i,
   output logic [7:0]                       rdData_o
);

   localparam int ROWS = DEPTH_BYTES / 4;

   logic [7:0] mem_q [ROWS];
   logic [7:0] rdData_q;

   // Storage array: written one byte per cycle, never reset.
   always @(posedge clk) begin
      if (we_i) begin
         mem_q[wrRow_i] <= wrData_i;
      end
   end

   // Registered read port; holds its last value while the read is disabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdData_q <= 8'h00;
      end else if (re_i) begin
         rdData_q <= mem_q[rdRow_i];
      end
   end

   assign rdData_o = rdData_q;

endmodule

// File: rtl/byte_mem_responder.sv
// Memory-side responder: returns a little-endian 4-byte window at any byte
// address with one cycle of read latency, and commits byte/halfword/word
// stores one byte per cycle with a level done handshake.
module byte_mem_responder
    import mem_pkg::*;
#(
    parameter int    DEPTH_BYTES = 4096,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [1:0]  write,
    input  logic [7:0]  d3,
    input  logic [7:0]  d2,
    input  logic [7:0]  d1,
    input  logic [7:0]  d0,
    output logic [7:0]  q3,
    output logic [7:0]  q2,
    output logic [7:0]  q1,
    output logic [7:0]  q0,
    output logic        done,
    output logic        error
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int RW = AW - 2;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q;
    logic [31:0]     data_q;
    logic [1:0]      size_q;
    logic [1:0]      count_q;
    logic            errFlag_q;
    logic            error_q;
    logic            done_q;
    logic [1:0]      readLane_q;

    logic            reqMisaligned;
    logic            reqOutOfRange;
    logic            reqReject;
    logic            lastByte;
    logic [AW-1:0]   writeIdx;
    logic [7:0]      writeByte;
    logic [7:0]      bankData [4];

    assign reqMisaligned = ((write == WR_HALF) && address[0]) ||
                           ((write == WR_WORD) && (address[1:0] != 2'b00));
    assign reqOutOfRange = (address >= 32'(DEPTH_BYTES));
    assign reqReject     = reqMisaligned || reqOutOfRange;
    assign lastByte      = ((3'(count_q) + 3'd1) == byteCount(size_q));

    // Accepted stores are aligned and in range, so addr + count never wraps.
    assign writeIdx  = addr_q + AW'(count_q);
    assign writeByte = data_q[{count_q, 3'b000} +: 8];

    // Next-state logic: accept or reject in IDLE, stream bytes, then hold done.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (write != WR_NONE) begin
                    state_d = reqReject ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (lastByte) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (write == WR_NONE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latches and byte counter; inputs are ignored once a store starts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q    <= '0;
            data_q    <= '0;
            size_q    <= WR_NONE;
            count_q   <= 2'd0;
            errFlag_q <= 1'b0;
        end else if ((state_q == IDLE) && (write != WR_NONE)) begin
            addr_q    <= address[AW-1:0];
            data_q    <= {d0, d1, d2, d3};
            size_q    <= write;
            count_q   <= 2'd0;
            errFlag_q <= reqReject;
        end else if (state_q == WRITE) begin
            count_q   <= count_q + 2'd1;
        end
    end

    // Handshake outputs lag the state by one edge; done drops as soon as the
    // core's request goes away.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            done_q  <= (state_q == DONE) && (state_d == DONE);
            error_q <= errFlag_q;
        end
    end

    // Remember which bank supplied byte 0 of the window being read.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            readLane_q <= 2'd0;
        end else if (state_q == IDLE) begin
            readLane_q <= address[1:0];
        end
    end

    for (genvar b = 0; b < 4; b++) begin : gBank
        logic [1:0]    readOffset;
        logic [AW-1:0] readIdx;
        logic          bankWe;

        assign readOffset = 2'(b) - address[1:0];
        assign readIdx    = address[AW-1:0] + AW'(readOffset);
        assign bankWe     = (state_q == WRITE) && (writeIdx[1:0] == 2'(b));

        byte_bank #(
            .DEPTH_BYTES(DEPTH_BYTES),
            .LANE       (b),
            .INIT_FILE  (INIT_FILE)
        ) uBank (
            .clk     (clk),
            .rst     (rst),
            .we_i    (bankWe),
            .wrRow_i (writeIdx[AW-1:2]),
            .wrData_i(writeByte),
            .re_i    (state_q == IDLE),
            .rdRow_i (readIdx[AW-1:2]),
            .rdData_o(bankData[b])
        );
    end

    assign q3    = bankData[readLane_q];
    assign q2    = bankData[readLane_q + 2'd1];
    assign q1    = bankData[readLane_q + 2'd2];
    assign q0    = bankData[readLane_q + 2'd3];
    assign done  = done_q;
    assign error = error_q;

    logic [RW-1:0] unusedRowBits;
    assign unusedRowBits = '0;

endmodule

// File: tb/tb_byte_mem_responder.sv
// Self-checking bench for byte_mem_responder: table-driven directed stores,
// constant read checks, reset-during-store, and randomized traffic against a
// flat byte-array model of memory.
module tb_byte_mem_responder;
    import mem_pkg::*;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address;
    logic [1:0]  write;
    logic [7:0]  d3, d2, d1, d0;
    logic [7:0]  q3, q2, q1, q0;
    logic        done, error;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] modelMem [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] data;
        bit          expErr;
        int          expLat;
    } vec_t;

    vec_t vecs [10];

    // Free-running clock.
    always #5 clk = ~clk;

    byte_mem_responder #(
        .DEPTH_BYTES(DEPTH),
        .INIT_FILE  ("")
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .address(address),
        .write  (write),
        .d3     (d3),
        .d2     (d2),
        .d1     (d1),
        .d0     (d0),
        .q3     (q3),
        .q2     (q2),
        .q1     (q1),
        .q0     (q0),
        .done   (done),
        .error  (error)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [1:0] s,
                                 input logic [31:0] data);
        address          = a;
        write            = s;
        {d0, d1, d2, d3} = data;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int sizeBytes(input logic [1:0] s);
        return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : (s == 2'd3) ? 4 : 0;
    endfunction

    function automatic bit modelReject(input logic [31:0] a, input logic [1:0] s);
        return (a >= 32'(DEPTH)) || (s == 2'd2 && a[0]) || (s == 2'd3 && a[1:0] != 2'd0);
    endfunction

    function automatic logic [31:0] modelWindow(input logic [31:0] a);
        logic [31:0] w;
        for (int i = 0; i < 4; i++) begin
            w[31 - 8 * i -: 8] = modelMem[(a + 32'(i)) % 32'(DEPTH)];
        end
        return w;
    endfunction

    // One complete store handshake: request, wait for done, drop the request.
    task automatic doStore(input logic [31:0] a, input logic [1:0] s,
                           input logic [31:0] data, input bit expErr,
                           input int expLat, input bit checkFreeze,
                           input string tag);
        logic [31:0] oldWin;
        int          lat;
        oldWin = modelWindow(a);
        lat    = 0;
        applyStimulus(a, s, data);
        tick();
        do begin
            tick();
            lat++;
        end while (done !== 1'b1 && lat < 20);
        checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
        checkOutput({tag, ".error"}, {31'd0, error}, {31'd0, expErr});
        if (checkFreeze) begin
            checkOutput({tag, ".frozenQ"}, {q3, q2, q1, q0}, oldWin);
        end
        if (!modelReject(a, s)) begin
            for (int k = 0; k < sizeBytes(s); k++) begin
                modelMem[(a + 32'(k)) % 32'(DEPTH)] = data[8 * k +: 8];
            end
        end
        applyStimulus(a, WR_NONE, 32'h0);
        tick();
        checkOutput({tag, ".doneDrop"}, {31'd0, done}, 32'd0);
    endtask

    task automatic readCheck(input logic [31:0] a, input string tag);
        applyStimulus(a, WR_NONE, $urandom());
        tick();
        checkOutput(tag, {q3, q2, q1, q0}, modelWindow(a));
    endtask

    initial begin
        vecs[0] = '{32'h00, WR_WORD, 32'h44332211, 1'b0, 5};
        vecs[1] = '{32'h10, WR_WORD, 32'hDEADBEEF, 1'b0, 5};
        vecs[2] = '{32'h22, WR_HALF, 32'h0000CAFE, 1'b0, 3};
        vecs[3] = '{32'h13, WR_WORD, 32'h01020304, 1'b1, 1};
        vecs[4] = '{32'h21, WR_HALF, 32'h0000BBAA, 1'b1, 1};
        vecs[5] = '{32'h05, WR_BYTE, 32'h0000005A, 1'b0, 2};
        vecs[6] = '{32'h40, WR_BYTE, 32'h00000099, 1'b1, 1};
        vecs[7] = '{32'h3C, WR_WORD, 32'h89ABCDEF, 1'b0, 5};
        vecs[8] = '{32'h3F, WR_BYTE, 32'h00000077, 1'b0, 2};
        vecs[9] = '{32'h3E, WR_HALF, 32'h00001234, 1'b0, 3};

        rst = 1'b0;
        applyStimulus(32'h0, WR_NONE, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.q", {q3, q2, q1, q0}, 32'h0);
        checkOutput("reset.done", {31'd0, done}, 32'd0);
        checkOutput("reset.error", {31'd0, error}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int w = 0; w < DEPTH / 4; w++) begin
            doStore(32'(4 * w), WR_WORD, $urandom(), 1'b0, 5, 1'b0, "fill");
        end

        for (int i = 0; i < 10; i++) begin
            doStore(vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].expErr,
                    vecs[i].expLat, 1'b1, $sformatf("vec%0d", i));
        end

        readCheck(32'h00, "rd00");
        checkOutput("rd00.const", {q3, q2, q1, q0}, 32'h11223344);
        readCheck(32'h01, "rd01");
        checkOutput("rd01.const", {8'h00, q3, q2, q1}, 32'h00223344);
        readCheck(32'h10, "rd10");
        checkOutput("rd10.const", {q3, q2, q1, q0}, 32'hEFBEADDE);
        readCheck(32'h22, "rd22");
        checkOutput("rd22.const", {16'h0, q3, q2}, 32'h0000FECA);
        readCheck(32'h20, "rd20");
        readCheck(32'h13, "rd13");
        readCheck(32'(DEPTH - 2), "rdWrap");
        checkOutput("rdWrap.const", {q3, q2, q1, q0}, 32'h34121122);
        readCheck(32'hFFFF_FFFE, "rdHighAddr");

        applyStimulus(32'h10, WR_WORD, 32'hA1B2C3D4);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("midReset.done", {31'd0, done}, 32'd0);
        checkOutput("midReset.error", {31'd0, error}, 32'd0);
        checkOutput("midReset.q", {q3, q2, q1, q0}, 32'h0);
        modelMem[16] = 8'hD4;
        modelMem[17] = 8'hC3;
        applyStimulus(32'h10, WR_NONE, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        checkOutput("midReset.doneAfter", {31'd0, done}, 32'd0);
        readCheck(32'h10, "midReset.mem");

        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            logic [1:0]  s;
            if ($urandom_range(0, 1) == 0) begin
                a = 32'($urandom_range(0, DEPTH + 7));
                s = 2'($urandom_range(1, 3));
                doStore(a, s, $urandom(), modelReject(a, s),
                        modelReject(a, s) ? 1 : sizeBytes(s) + 1, 1'b1,
                        $sformatf("rndStore%0d", n));
            end else begin
                a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, DEPTH - 1));
                readCheck(a, $sformatf("rndRead%0d", n));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
